// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-back, write-allocate data cache, 2-word blocks.
// Rev 1.0
`default_nettype none

module dcache_dm #(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 3 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WB0   = 4'd1,
    S_WB1   = 4'd2,
    S_LD0   = 4'd3,
    S_LD1   = 4'd4,
    S_FLUSH = 4'd5,
    S_FWB0  = 4'd6,
    S_FWB1  = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  state_e             state_q;
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [IDX_W-1:0]   fidx_q;
  logic [TAG_W-1:0]   tag_q   [SETS];
  logic [31:0]        word0_q [SETS];
  logic [31:0]        word1_q [SETS];
  logic [31:0]        fill0_q;

  logic               req;
  logic               is_store;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               req_word;
  logic               hit_raw;
  logic               hit;
  logic [31:0]        sel_word;
  logic               unused_addr_bits;

  assign req      = dmemREN | dmemWEN;
  assign is_store = dmemWEN;
  assign req_tag  = dmemaddr[31:IDX_W+3];
  assign req_idx  = dmemaddr[IDX_W+2:3];
  assign req_word = dmemaddr[2];
  assign unused_addr_bits = ^dmemaddr[1:0];

  assign hit_raw  = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // halt wins over a coincident request, even one that would hit
  assign hit      = (state_q == S_IDLE) && !halt && hit_raw;
  assign sel_word = req_word ? word1_q[req_idx] : word0_q[req_idx];

  assign dhit     = hit;
  assign dmemload = hit ? sel_word : 32'h0;
  assign flushed  = (state_q == S_DONE);

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'h0;
    dstore = 32'h0;
    case (state_q)
      S_WB0: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 1'b0, 2'b00};
        dstore = word0_q[req_idx];
      end
      S_WB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 1'b1, 2'b00};
        dstore = word1_q[req_idx];
      end
      S_LD0: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b0, 2'b00};
      end
      S_LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b1, 2'b00};
      end
      S_FWB0: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fidx_q], fidx_q, 1'b0, 2'b00};
        dstore = word0_q[fidx_q];
      end
      S_FWB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fidx_q], fidx_q, 1'b1, 2'b00};
        dstore = word1_q[fidx_q];
      end
      default: begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = 32'h0;
        dstore = 32'h0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      fidx_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (halt) begin
            state_q <= S_FLUSH;
            fidx_q  <= '0;
          end else if (req) begin
            if (hit_raw) begin
              if (is_store) dirty_q[req_idx] <= 1'b1;
            end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q <= S_WB0;
            end else begin
              state_q <= S_LD0;
            end
          end
        end
        S_WB0: if (!dwait) state_q <= S_WB1;
        S_WB1: if (!dwait) state_q <= S_LD0;
        S_LD0: if (!dwait) state_q <= S_LD1;
        S_LD1: begin
          if (!dwait) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
            state_q <= S_FWB0;
          end else if (fidx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            fidx_q <= fidx_q + 1'b1;
          end
        end
        S_FWB0: if (!dwait) state_q <= S_FWB1;
        S_FWB1: begin
          if (!dwait) begin
            dirty_q[fidx_q] <= 1'b0;
            if (fidx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              fidx_q  <= fidx_q + 1'b1;
              state_q <= S_FLUSH;
            end
          end
        end
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Frame payload needs no reset; the first word of a fill is buffered so a
  // fill interrupted by reset never lands in the frame.
  always_ff @(posedge CLK) begin
    if (hit && is_store) begin
      if (req_word) word1_q[req_idx] <= dmemstore;
      else          word0_q[req_idx] <= dmemstore;
    end
    if (state_q == S_LD0 && !dwait) begin
      fill0_q <= dload;
    end
    if (state_q == S_LD1 && !dwait) begin
      tag_q[req_idx]   <= req_tag;
      word0_q[req_idx] <= fill0_q;
      word1_q[req_idx] <= dload;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: vector table plus hand sequences for miss, dwait, flush and reset.
// Rev 1.0
`default_nettype none

module tb_dcache_dm;

  localparam int SETS = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, halt, dwait;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, dload;

  dcache_dm #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t beats[$];
  logic [31:0] exp_q[$];

  assign dload = mem[daddr[11:2]];

  always @(posedge CLK) begin
    if (nRST && !dwait) begin
      if (dWEN) begin
        beats.push_back({1'b1, daddr, dstore});
        mem[daddr[11:2]] = dstore;
      end else if (dREN) begin
        beats.push_back({1'b0, daddr, dload});
      end
    end
  end

  always @(negedge CLK) begin
    if ((dREN && dWEN) || (!dWEN && dstore != 32'h0) || (!dREN && !dWEN && daddr != 32'h0)) begin
      miscompares++;
      $display("FAIL bus_invariant: dREN=%b dWEN=%b daddr=%h dstore=%h", dREN, dWEN, daddr, dstore);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input int pos, input logic we,
                            input logic [31:0] addr, input logic [31:0] data);
    beat_t b;
    if (pos >= beats.size()) begin
      check32({name, " present"}, 32'(beats.size()), 32'(pos + 1));
    end else begin
      b = beats[pos];
      check32({name, " we"},   {31'h0, b.we}, {31'h0, we});
      check32({name, " addr"}, b.addr, addr);
      check32({name, " data"}, b.data, data);
    end
  endtask

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
    int          nbeats;
  } vec_t;

  task automatic do_access(input string name, input vec_t v);
    int  n;
    int  b0;
    logic got;
    logic is_load;
    b0 = beats.size();
    is_load = v.ren && !v.wen;
    @(posedge CLK); #1;
    dmemREN = v.ren; dmemWEN = v.wen; dmemaddr = v.addr; dmemstore = v.wdata;
    if (is_load) exp_q.push_back(ref_mem[v.addr[11:2]]);
    if (v.wen) ref_mem[v.addr[11:2]] = v.wdata;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (dhit) begin
        got = 1'b1;
        if (is_load) check32({name, " data"}, dmemload, exp_q.pop_front());
      end
    end
    if (!got && is_load) void'(exp_q.pop_front());
    check32({name, " latency"}, 32'(n), 32'(v.cycles));
    check32({name, " beats"}, 32'(beats.size() - b0), 32'(v.nbeats));
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic sync_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
  endtask

  vec_t tbl[11];
  int   bstart;
  int   n;
  logic [31:0] exp_w;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 ^ (i * 32'h0001_0004);
      ref_mem[i] = mem[i];
    end
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'h0; dmemstore = 32'h0;
    halt = 1'b0; dwait = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          4, 2};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  1, 0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          1, 0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0240, 32'h0,          6, 4};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          4, 2};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          1, 0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h1111_2222,  4, 2};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0068, 32'h3333_4444,  4, 2};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,          1, 0};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_006C, 32'h5555_6666,  1, 0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_006C, 32'h0,          1, 0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check32("rst dhit",     {31'h0, dhit},    32'h0);
    check32("rst dREN",     {31'h0, dREN},    32'h0);
    check32("rst dWEN",     {31'h0, dWEN},    32'h0);
    check32("rst flushed",  {31'h0, flushed}, 32'h0);
    check32("rst daddr",    daddr,            32'h0);
    check32("rst dstore",   dstore,           32'h0);
    check32("rst dmemload", dmemload,         32'h0);
    @(posedge CLK); #1 nRST = 1'b1;

    for (int i = 0; i < 11; i++) begin
      bstart = beats.size();
      do_access($sformatf("vec%0d", i), tbl[i]);
      if (i == 0) begin
        check_beat("fill0 rd0", bstart,     1'b0, 32'h40, mem[16]);
        check_beat("fill0 rd1", bstart + 1, 1'b0, 32'h44, mem[17]);
      end
      if (i == 3) begin
        check_beat("evict wb0", bstart,     1'b1, 32'h40,  ref_mem[16]);
        check_beat("evict wb1", bstart + 1, 1'b1, 32'h44,  32'hDEAD_BEEF);
        check_beat("evict rd0", bstart + 2, 1'b0, 32'h240, ref_mem[144]);
        check_beat("evict rd1", bstart + 3, 1'b0, 32'h244, ref_mem[145]);
      end
    end

    // LD0 held off by dwait for three cycles
    bstart = beats.size();
    @(posedge CLK); #1;
    dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h80;
    exp_q.push_back(ref_mem[32]);
    @(negedge CLK);
    check32("dw miss dhit", {31'h0, dhit}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check32($sformatf("dw%0d dREN", k), {31'h0, dREN}, 32'h1);
      check32($sformatf("dw%0d daddr", k), daddr, 32'h80);
      check32($sformatf("dw%0d dhit", k), {31'h0, dhit}, 32'h0);
    end
    dwait = 1'b0;
    @(negedge CLK);
    check32("dw ld1 daddr", daddr, 32'h84);
    @(negedge CLK);
    check32("dw hit", {31'h0, dhit}, 32'h1);
    check32("dw data", dmemload, exp_q.pop_front());
    check32("dw beats", 32'(beats.size() - bstart), 32'd2);
    @(posedge CLK); #1 dmemREN = 1'b0;

    // flush with frames 1 and 5 dirty
    bstart = beats.size();
    @(posedge CLK); #1 halt = 1'b1;
    n = 0;
    while (!flushed && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check32("flush flushed", {31'h0, flushed}, 32'h1);
    vectors++;
    if (n < SETS + 2) begin
      miscompares++;
      $display("FAIL flush time: got %0d cycles expected at least %0d", n, SETS + 2);
    end
    check32("flush beats", 32'(beats.size() - bstart), 32'd4);
    check_beat("flush f1w0", bstart,     1'b1, 32'h48, ref_mem[18]);
    check_beat("flush f1w1", bstart + 1, 1'b1, 32'h4C, ref_mem[19]);
    check_beat("flush f5w0", bstart + 2, 1'b1, 32'h68, ref_mem[26]);
    check_beat("flush f5w1", bstart + 3, 1'b1, 32'h6C, ref_mem[27]);
    check32("flush mem 0x6C", mem[27], 32'h5555_6666);
    dmemREN = 1'b1; dmemaddr = 32'h80;
    repeat (4) begin
      @(negedge CLK);
      check32("done flushed", {31'h0, flushed}, 32'h1);
      check32("done dhit", {31'h0, dhit}, 32'h0);
    end
    dmemREN = 1'b0; halt = 1'b0;

    // reset during WB1 of a dirty miss
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    sync_ref();
    do_access("rst store", '{1'b0, 1'b1, 32'h40, 32'h7777_8888, 4, 2});
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h240;
    @(negedge CLK);
    check32("wbr idle dhit", {31'h0, dhit}, 32'h0);
    @(negedge CLK);
    check32("wbr wb0 dWEN", {31'h0, dWEN}, 32'h1);
    check32("wbr wb0 daddr", daddr, 32'h40);
    @(negedge CLK);
    check32("wbr wb1 dWEN", {31'h0, dWEN}, 32'h1);
    check32("wbr wb1 daddr", daddr, 32'h44);
    check32("wbr wb1 dstore", dstore, ref_mem[17]);
    #1 nRST = 1'b0;
    #1;
    check32("wbr async dWEN", {31'h0, dWEN}, 32'h0);
    check32("wbr async daddr", daddr, 32'h0);
    dmemREN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    sync_ref();
    for (int i = 0; i < SETS; i++) begin
      do_access($sformatf("post rst f%0d", i), '{1'b1, 1'b0, 32'(32'h40 + i * 8), 32'h0, 4, 2});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
